// File: rtl/alarm_siren_scheduler.sv
// rtl/alarm_siren_scheduler.sv - shares one siren between fire, burglar and rain hazards
//
// Latches hazard events, serves the highest-priority pending one (fire > burglar > rain)
// with a repeating ON_CYCLES-high / OFF_CYCLES-low siren pattern until acknowledged.
// A higher-priority event preempts the current one; the preempted event stays pending.
//
// Optional feature macro: ALARM_TIMEOUT_EN - when defined, a served hazard that is not
// acknowledged within TIMEOUT_CYCLES cycles is auto-cleared and the sticky timeout flag set.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   fire       in   level fire flag
//   burglar    in   level burglar flag
//   rain       in   level rain flag
//   ack        in   user acknowledge (pulse or level)
//   siren      out  registered siren drive
//   active_src out  served hazard: 00 none, 01 rain, 10 burglar, 11 fire
//   pending    out  latched events {fire, burglar, rain}
//   busy       out  high while a hazard is being served
//   timeout    out  sticky auto-clear flag (constant 0 without ALARM_TIMEOUT_EN)

module alarm_siren_scheduler #(
    parameter int ON_CYCLES      = 4,
    parameter int OFF_CYCLES     = 2,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic       burglar,
    input  logic       rain,
    input  logic       ack,
    output logic       siren,
    output logic [1:0] active_src,
    output logic [2:0] pending,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    localparam logic [CNT_W-1:0] ON_RELOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_RELOAD = CNT_W'(OFF_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       src_q, src_d;
    logic [2:0]       pend_q, pend_d;
    logic             siren_q, siren_d;

    logic [1:0]       hp_src;
    logic             serving;
    logic             auto_ack;
    logic             ack_take;
    logic             preempt;
    logic [2:0]       clr_mask;

    always_comb begin
        if (pend_q[2])      hp_src = 2'd3;
        else if (pend_q[1]) hp_src = 2'd2;
        else if (pend_q[0]) hp_src = 2'd1;
        else                hp_src = 2'd0;
    end

    assign serving  = (state_q != S_IDLE);
    // Ack only means something while a hazard is served; in IDLE it is dropped.
    assign ack_take = serving && (ack || auto_ack);
    assign preempt  = serving && (hp_src > src_q);

    always_comb begin
        clr_mask = 3'b000;
        if (ack_take) begin
            case (src_q)
                2'd1:    clr_mask = 3'b001;
                2'd2:    clr_mask = 3'b010;
                2'd3:    clr_mask = 3'b100;
                default: clr_mask = 3'b000;
            endcase
        end
    end

    // OR-ing the live flags after the clear makes a still-high flag win over its ack.
    assign pend_d = (pend_q & ~clr_mask) | {fire, burglar, rain};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q != 3'b000) begin
                    state_d = S_ON;
                    src_d   = hp_src;
                    cnt_d   = ON_RELOAD;
                end
            end
            S_ON, S_OFF: begin
                if (ack_take) begin
                    // Ack beats preemption; the higher source is granted from IDLE next.
                    state_d = S_IDLE;
                    src_d   = 2'd0;
                end else if (preempt) begin
                    state_d = S_ON;
                    src_d   = hp_src;
                    cnt_d   = ON_RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = (state_q == S_ON) ? S_OFF : S_ON;
                    cnt_d   = (state_q == S_ON) ? OFF_RELOAD : ON_RELOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                src_d   = 2'd0;
            end
        endcase
    end

    assign siren_d = (state_d == S_ON);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= 2'd0;
            pend_q  <= 3'b000;
            siren_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            siren_q <= siren_d;
        end
    end

`ifdef ALARM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_q, timeout_d;

    // Counts served cycles since the last grant, preemption or ack.
    assign auto_ack  = serving && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign tmo_d     = (!serving || ack_take || preempt) ? '0 : tmo_q + 1'b1;
    assign timeout_d = timeout_q | auto_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign auto_ack           = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    assign siren      = siren_q;
    assign active_src = src_q;
    assign pending    = pend_q;
    assign busy       = serving;

endmodule

// File: tb/tb_alarm_siren_scheduler.sv
// tb/tb_alarm_siren_scheduler.sv - randomized self-checking bench for alarm_siren_scheduler

module tb_alarm_siren_scheduler;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fire = 1'b0, burglar = 1'b0, rain = 1'b0, ack = 1'b0;
    logic       siren, busy, timeout;
    logic [1:0] active_src;
    logic [2:0] pending;

    int checks = 0;
    int failures = 0;

    // Reference: who is served (0 none, 1 rain, 2 burglar, 3 fire) and how many
    // cycles since the grant; the siren level follows from time modulo the period.
    int         m_src;
    int         m_t;
    int         m_tc;
    bit         m_tmo;
    bit [2:0]   m_pend;

    alarm_siren_scheduler #(
        .ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(8), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .fire(fire), .burglar(burglar), .rain(rain),
        .ack(ack), .siren(siren), .active_src(active_src), .pending(pending),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int top_pending(input bit [2:0] p);
        if (p[2]) return 3;
        if (p[1]) return 2;
        if (p[0]) return 1;
        return 0;
    endfunction

    task automatic model_edge(input bit f, input bit b, input bit r, input bit a, input bit rs);
        bit [2:0] clr;
        bit       serving;
        bit       auto;
        int       hp;
        clr = 3'b000;
        if (rs) begin
            m_pend = 3'b000; m_src = 0; m_t = 0; m_tc = 0; m_tmo = 0;
            return;
        end
        serving = (m_src != 0);
        hp      = top_pending(m_pend);
`ifdef ALARM_TIMEOUT_EN
        auto = serving && (m_tc == TMO - 1);
`else
        auto = 0;
`endif
        if (serving && (a || auto)) begin
            clr    = 3'b001 << (m_src - 1);
            m_src  = 0;
            m_tc   = 0;
            if (auto) m_tmo = 1;
        end else if (serving && hp > m_src) begin
            m_src = hp; m_t = 0; m_tc = 0;
        end else if (!serving && m_pend != 0) begin
            m_src = hp; m_t = 0; m_tc = 0;
        end else if (serving) begin
            m_t++; m_tc++;
        end
        m_pend = (m_pend & ~clr) | {f, b, r};
    endtask

    task automatic step(input bit f, input bit b, input bit r, input bit a, input bit rs);
        fire = f; burglar = b; rain = r; ack = a; reset = rs;
        @(posedge clk);
        model_edge(f, b, r, a, rs);
        #1;
        check_eq("siren", int'(siren), int'(m_src != 0 && (m_t % (ON + OFF)) < ON));
        check_eq("active_src", int'(active_src), m_src);
        check_eq("pending", int'(pending), int'(m_pend));
        check_eq("busy", int'(busy), int'(m_src != 0));
        check_eq("timeout", int'(timeout), int'(m_tmo));
    endtask

    initial begin
        // Reset held with every flag high: nothing may latch.
        step(1, 1, 1, 0, 1);
        check_eq("rst_pending", int'(pending), 0);
        check_eq("rst_siren", int'(siren), 0);
        step(1, 1, 1, 1, 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_src", int'(active_src), 0);

        // Rain pulse, two full periods plus some, then ack pulse.
        step(0, 0, 1, 0, 0);
        check_eq("rain_latched", int'(pending), 3'b001);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_eq("rain_ack_busy", int'(busy), 0);
        check_eq("rain_ack_pending", int'(pending), 0);

        // Rain served, burglar arrives mid-ON and preempts; ack burglar, rain returns.
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check_eq("preempt_pending", int'(pending), 3'b011);
        step(0, 0, 0, 0, 0);
        check_eq("preempt_src", int'(active_src), 2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_eq("after_burglar_src", int'(active_src), 0);
        step(0, 0, 0, 0, 0);
        check_eq("rain_regrant", int'(active_src), 1);
        step(0, 0, 0, 1, 0);

        // All three at once: served fire, burglar, rain in that order.
        step(1, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
            check_eq("order_src", int'(active_src), 3 - k);
            step(0, 0, 0, 1, 0);
        end
        step(0, 0, 0, 0, 0);
        check_eq("order_done", int'(pending), 0);

        // Fire held high through its ack: one IDLE cycle, then re-granted.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        check_eq("held_fire_pending", int'(pending), 3'b100);
        check_eq("held_fire_idle", int'(busy), 0);
        step(1, 0, 0, 0, 0);
        check_eq("held_fire_regrant", int'(active_src), 3);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Randomized traffic, with occasional held acks and mid-pattern resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_siren_scheduler.md
Name: alarm_siren_scheduler

Overview:
- Shares one physical siren between the three hazard flags from the `alarms` block: fire, burglar and rain.
- Latches each hazard event, grants the siren to the highest-priority pending hazard, and drives a timed on/off siren pattern until the user acknowledges.
- Sits between the `alarms` outputs and the siren driver / status display of the smart-home top level.

Parameters:
- ON_CYCLES, 4, siren-high cycles per pattern period (>=1)
- OFF_CYCLES, 2, siren-low cycles per pattern period (>=1)
- CNT_W, 8, width of the pattern counter; must satisfy max(ON_CYCLES, OFF_CYCLES) <= 2^CNT_W
- TIMEOUT_CYCLES, 64, auto-clear limit (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- fire  input  1  level fire flag from `alarms`
- burglar  input  1  level burglar flag from `alarms`
- rain  input  1  level rain flag from `alarms`
- ack  input  1  user acknowledge; single-cycle or level
- siren  output  1  registered siren drive
- active_src  output  2  served hazard: 00 none, 01 rain, 10 burglar, 11 fire
- pending  output  3  latched events as {fire, burglar, rain}
- busy  output  1  high when state != IDLE
- timeout  output  1  sticky auto-clear flag; tied to 0 when ALARM_TIMEOUT_EN is undefined

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, siren=0, active_src=00, pending=000, busy=0, timeout=0, counter=0.
- Reset dominates every other input on the same edge. Reset mid-pattern ends the pattern at the next edge.
- Latch rule, each edge: pending <= (pending & ~clr_mask) | {fire, burglar, rain}.
  - clr_mask is the one-hot bit of active_src when an ack is accepted.
  - Set beats clear: a flag still high on the ack edge keeps its bit. A persisting hazard therefore re-alerts after one IDLE cycle.
- Priority: fire > burglar > rain. Fixed, not rotating.
- FSM states: IDLE, ON, OFF.
  - IDLE: if pending != 0, go to ON next edge with active_src = highest pending bit and counter = ON_CYCLES-1.
  - ON: siren=1. Counter decrements each cycle. At 0, go to OFF with counter = OFF_CYCLES-1.
  - OFF: siren=0. At counter 0, go to ON with counter = ON_CYCLES-1. The pattern repeats indefinitely.
- Latency:
  - Flag high at edge N gives pending bit set after N.
  - FSM enters ON and siren=1 after edge N+1.
  - Siren stays high exactly ON_CYCLES cycles, then low exactly OFF_CYCLES cycles.
- Ack:
  - Accepted only in ON or OFF. Ack in IDLE is ignored.
  - On the accepting edge: clear the active pending bit, go to IDLE, siren=0, active_src=00.
  - An ack held high is honoured once per grant. Re-grant still requires an IDLE cycle.
- Preemption: in ON/OFF, if a pending bit of higher priority than active_src is set, the next edge goes to ON with the new source and counter = ON_CYCLES-1. The preempted bit stays pending.
- Ack and preemption on the same edge: ack wins. Go to IDLE; the higher source is granted on the following edge.
- Counter and active_src are held in IDLE. The counter never wraps; it is reloaded before reaching 0-1.

Optional Feature:
- Macro: ALARM_TIMEOUT_EN.
- Defined:
  - A TIMEOUT counter counts cycles in ON/OFF without ack. It resets on every grant, preemption and ack.
  - On reaching TIMEOUT_CYCLES-1, the block behaves exactly as an ack and sets timeout=1.
  - timeout stays 1 until reset.
- Undefined: no timeout counter; timeout is constant 0; the siren sounds until ack.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2):
- Reset held 2 cycles with all flags high -> siren=0, pending=000, active_src=00, busy=0 throughout the reset.
- rain pulse 1 cycle at edge N -> pending=001 after N. Siren high for 4 cycles from N+1, low 2, high 4. active_src=01. Ack pulse then gives siren=0, pending=000, busy=0 next cycle.
- rain granted, then burglar pulse mid-ON -> active_src=10 and counter reloaded 2 edges later. pending=011. Ack serves burglar; rain is re-granted after one IDLE cycle.
- fire, burglar and rain pulse on the same edge -> grant order fire, burglar, rain across three acks. pending goes 111 -> 011 -> 001 -> 000.
- fire held high continuously plus ack -> pending[2] stays 1. IDLE for 1 cycle, then fire re-granted.
- With ALARM_TIMEOUT_EN and TIMEOUT_CYCLES=16: burglar pulse, no ack -> auto-clear 16 cycles after grant. timeout=1 and stays high until reset.
